// File: rtl/omsp_hmac_msg_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : omsp_hmac_msg_buffer_if
// Description : FSM-side request/response and core-side block/digest signals
//               of the HMAC message buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface omsp_hmac_msg_buffer_if #(
    parameter int RATE_BYTES   = 8,
    parameter int DIGEST_BYTES = 16
);
    logic                      hmac_reset;
    logic                      start_continue;
    logic                      data_available;
    logic                      data_is_long;
    logic [15:0]               data_in;
    logic                      busy;
    logic [15:0]               data_out;
    logic                      core_clear;
    logic                      blk_valid;
    logic                      blk_ready;
    logic [8*RATE_BYTES-1:0]   blk_data;
    logic                      blk_last;
    logic                      digest_valid;
    logic [8*DIGEST_BYTES-1:0] digest;

    modport slave (
        input  hmac_reset, start_continue, data_available, data_is_long, data_in,
        input  blk_ready, digest_valid, digest,
        output busy, data_out, core_clear, blk_valid, blk_data, blk_last
    );

    modport master (
        output hmac_reset, start_continue, data_available, data_is_long, data_in,
        output blk_ready, digest_valid, digest,
        input  busy, data_out, core_clear, blk_valid, blk_data, blk_last
    );
endinterface
`default_nettype wire

// File: rtl/omsp_hmac_msg_buffer.sv
`default_nettype none
// ============================================================================
// Module      : omsp_hmac_msg_buffer
// Description : Packs 16-bit message words into rate blocks, applies 10*
//               padding on finalize and serves the digest one word at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module omsp_hmac_msg_buffer #(
    parameter int RATE_BYTES   = 8,
    parameter int DIGEST_BYTES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    omsp_hmac_msg_buffer_if.slave bus
);
    localparam int CNT_W = $clog2(RATE_BYTES + 2);
    localparam int WORDS = DIGEST_BYTES / 2;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BLK_W = 8 * RATE_BYTES;

    localparam logic [2:0] ST_ABSORB      = 3'd0;
    localparam logic [2:0] ST_FLUSH       = 3'd1;
    localparam logic [2:0] ST_PAD_FLUSH   = 3'd2;
    localparam logic [2:0] ST_WAIT_DIGEST = 3'd3;
    localparam logic [2:0] ST_OUT         = 3'd4;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RATE_BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    logic [2:0]       state;
    logic [BLK_W-1:0] buffer;
    logic [CNT_W-1:0] cnt;
    logic             split_pending;
    logic [7:0]       split_byte;
    logic             pad_pending;
    logic             blk_last_q;
    logic [IDX_W-1:0] idx;
    logic [15:0]      data_out_q;
    logic             core_clear_q;

    logic [CNT_W-1:0] cnt_p1;
    logic [CNT_W-1:0] cnt_add;
    logic [7:0]       first_byte;
    logic             fills;
    logic             split;
    logic [BLK_W-1:0] buf_abs;
    logic [BLK_W-1:0] buf_fin;
    logic [IDX_W-1:0] idx_nxt;
    logic [15:0]      word_nxt;
    logic             busy_c;

    // Byte lanes are addressed by byte count; byte 0 sits in the MSBs.
    always_comb begin
        first_byte = bus.data_is_long ? bus.data_in[15:8] : bus.data_in[7:0];
        cnt_p1     = cnt + CNT_W'(1);
        cnt_add    = bus.data_is_long ? (cnt + CNT_W'(2)) : cnt_p1;
        fills      = (cnt_add >= CNT_FULL);
        split      = bus.data_is_long && (cnt_p1 == CNT_FULL);
        buf_abs    = buffer;
        buf_fin    = buffer;
        for (int i = 0; i < RATE_BYTES; i++) begin
            if (cnt == CNT_W'(i)) begin
                buf_abs[8*(RATE_BYTES-i)-1 -: 8] = first_byte;
                buf_fin[8*(RATE_BYTES-i)-1 -: 8] = 8'h80;
            end
            if (bus.data_is_long && (cnt_p1 == CNT_W'(i))) begin
                buf_abs[8*(RATE_BYTES-i)-1 -: 8] = bus.data_in[7:0];
            end
        end
    end

    always_comb begin
        idx_nxt  = (idx == IDX_LAST) ? '0 : (idx + IDX_W'(1));
        word_nxt = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                word_nxt = bus.digest[8*DIGEST_BYTES-1-16*i -: 16];
            end
        end
    end

    always_comb begin
        case (state)
            ST_ABSORB: busy_c = bus.start_continue && (!bus.data_available || fills);
            ST_OUT:    busy_c = bus.start_continue;
            default:   busy_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        core_clear_q <= reset | bus.hmac_reset;
    end

    always_ff @(posedge clk) begin
        if (reset || bus.hmac_reset) begin
            state         <= ST_ABSORB;
            buffer        <= '0;
            cnt           <= '0;
            split_pending <= 1'b0;
            split_byte    <= 8'h00;
            pad_pending   <= 1'b0;
            blk_last_q    <= 1'b0;
            idx           <= '0;
            data_out_q    <= 16'h0000;
        end else begin
            case (state)
                ST_ABSORB: begin
                    if (bus.start_continue && bus.data_available) begin
                        buffer <= buf_abs;
                        if (fills) begin
                            state         <= ST_FLUSH;
                            cnt           <= CNT_FULL;
                            split_pending <= split;
                            split_byte    <= bus.data_in[7:0];
                        end else begin
                            cnt <= cnt_add;
                        end
                    end else if (bus.start_continue) begin
                        // A full buffer must go out before a padding block can follow.
                        if (cnt == CNT_FULL) begin
                            state       <= ST_FLUSH;
                            pad_pending <= 1'b1;
                        end else begin
                            buffer     <= buf_fin;
                            blk_last_q <= 1'b1;
                            state      <= ST_PAD_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (bus.blk_ready) begin
                        if (pad_pending) begin
                            buffer      <= {8'h80, {(BLK_W-8){1'b0}}};
                            cnt         <= '0;
                            pad_pending <= 1'b0;
                            blk_last_q  <= 1'b1;
                            state       <= ST_PAD_FLUSH;
                        end else if (split_pending) begin
                            buffer        <= {split_byte, {(BLK_W-8){1'b0}}};
                            cnt           <= CNT_W'(1);
                            split_pending <= 1'b0;
                            state         <= ST_ABSORB;
                        end else begin
                            buffer <= '0;
                            cnt    <= '0;
                            state  <= ST_ABSORB;
                        end
                    end
                end
                ST_PAD_FLUSH: begin
                    if (bus.blk_ready) begin
                        buffer     <= '0;
                        cnt        <= '0;
                        blk_last_q <= 1'b0;
                        state      <= ST_WAIT_DIGEST;
                    end
                end
                ST_WAIT_DIGEST: begin
                    if (bus.digest_valid) begin
                        data_out_q <= bus.digest[8*DIGEST_BYTES-1 -: 16];
                        idx        <= '0;
                        state      <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.start_continue) begin
                        idx        <= idx_nxt;
                        data_out_q <= word_nxt;
                    end
                end
                default: state <= ST_ABSORB;
            endcase
        end
    end

    assign bus.busy       = busy_c;
    assign bus.data_out   = data_out_q;
    assign bus.core_clear = core_clear_q;
    assign bus.blk_valid  = (state == ST_FLUSH) || (state == ST_PAD_FLUSH);
    assign bus.blk_data   = buffer;
    assign bus.blk_last   = blk_last_q;

endmodule
`default_nettype wire

// File: tb/tb_omsp_hmac_msg_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_omsp_hmac_msg_buffer
// Description : Randomized self-checking bench against a byte-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_omsp_hmac_msg_buffer;
    localparam int RB = 8;
    localparam int DB = 16;
    localparam int NW = DB / 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    byte unsigned pend[$];

    omsp_hmac_msg_buffer_if #(.RATE_BYTES(RB), .DIGEST_BYTES(DB)) bus();
    omsp_hmac_msg_buffer #(.RATE_BYTES(RB), .DIGEST_BYTES(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Model: message bytes in arrival order; a block is the next RB of them.
    function automatic logic [8*RB-1:0] pop_block();
        logic [8*RB-1:0] b = '0;
        for (int i = 0; i < RB; i++) b = {b[8*RB-9:0], pend.pop_front()};
        return b;
    endfunction

    task automatic pulse(input logic dav, input logic lng, input logic [15:0] d,
                         output logic busy_seen);
        @(negedge clk);
        bus.start_continue = 1'b1;
        bus.data_available = dav;
        bus.data_is_long   = lng;
        bus.data_in        = d;
        #1 busy_seen = bus.busy;
        @(posedge clk); #1;
        bus.start_continue = 1'b0;
        bus.data_available = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic consume_block(input logic [8*RB-1:0] exp, input logic exp_last,
                                 input int hold, input string name);
        int waited = 0;
        while (bus.blk_valid !== 1'b1 && waited < 16) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (bus.blk_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s blk_valid: got %b required 1 within 16 cycles", name, bus.blk_valid);
            return;
        end
        checks++;
        if (bus.blk_data !== exp || bus.blk_last !== exp_last) begin
            errors++;
            $display("FAIL %s block: got %h last=%b required %h last=%b",
                     name, bus.blk_data, bus.blk_last, exp, exp_last);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.blk_data !== exp || bus.busy !== 1'b1 || bus.blk_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s hold: got data=%h busy=%b valid=%b required %h 1 1",
                         name, bus.blk_data, bus.busy, bus.blk_valid, exp);
            end
        end
        @(negedge clk) bus.blk_ready = 1'b1;
        @(posedge clk); #1 bus.blk_ready = 1'b0;
        checks++;
        if (bus.blk_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s release: got blk_valid=%b required 0", name, bus.blk_valid);
        end
    endtask

    task automatic absorb(input logic [15:0] w, input logic lng, input int hold, input string name);
        logic b;
        logic exp_busy;
        exp_busy = (pend.size() + (lng ? 2 : 1)) >= RB;
        if (lng) pend.push_back(w[15:8]);
        pend.push_back(w[7:0]);
        pulse(1'b1, lng, w, b);
        checks++;
        if (b !== exp_busy) begin
            errors++;
            $display("FAIL %s absorb busy: got %b required %b (word %h)", name, b, exp_busy, w);
        end
        if (pend.size() >= RB) consume_block(pop_block(), 1'b0, hold, name);
    endtask

    task automatic finalize(input int hold, input string name);
        logic b;
        pulse(1'b0, 1'($urandom % 2), 16'($urandom), b);
        checks++;
        if (b !== 1'b1) begin
            errors++;
            $display("FAIL %s finalize busy: got %b required 1", name, b);
        end
        pend.push_back(8'h80);
        while (pend.size() < RB) pend.push_back(8'h00);
        consume_block(pop_block(), 1'b1, hold, name);
        pend.delete();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s wait_digest busy: got %b required 1", name, bus.busy);
        end
    endtask

    task automatic read_digest(input logic [8*DB-1:0] dig, input int npulses, input string name);
        logic b;
        logic [8*DB-1:0] sh;
        bus.digest = dig;
        @(negedge clk) bus.digest_valid = 1'b1;
        @(posedge clk); #1;
        sh = dig >> (16 * (NW - 1));
        checks++;
        if (bus.data_out !== sh[15:0] || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s word0: got %h busy=%b required %h busy=0", name, bus.data_out, bus.busy, sh[15:0]);
        end
        for (int k = 1; k <= npulses; k++) begin
            pulse(1'($urandom % 2), 1'b1, 16'($urandom), b);
            sh = dig >> (16 * (NW - 1 - (k % NW)));
            checks++;
            if (b !== 1'b1 || bus.data_out !== sh[15:0]) begin
                errors++;
                $display("FAIL %s pulse %0d: got %h busy=%b required %h busy=1",
                         name, k, bus.data_out, b, sh[15:0]);
            end
        end
        bus.digest_valid = 1'b0;
    endtask

    task automatic soft_reset();
        @(negedge clk) bus.hmac_reset = 1'b1;
        @(posedge clk); #1 bus.hmac_reset = 1'b0;
        pend.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start_continue = 1'b1;
        bus.data_available = 1'b1;
        bus.data_is_long   = 1'b1;
        bus.data_in        = 16'hDEAD;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.blk_valid !== 1'b0 || bus.blk_last !== 1'b0 || bus.blk_data !== '0 ||
            bus.data_out !== 16'h0 || bus.core_clear !== 1'b1) begin
            errors++;
            $display("FAIL reset state: got valid=%b last=%b data=%h out=%h clr=%b required 0 0 0 0 1",
                     bus.blk_valid, bus.blk_last, bus.blk_data, bus.data_out, bus.core_clear);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.start_continue = 1'b0;
        bus.data_available = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset busy: got %b required 0", bus.busy);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.core_clear !== 1'b0) begin
            errors++;
            $display("FAIL reset core_clear release: got %b required 0", bus.core_clear);
        end
    endtask

    task automatic test_finalize_basic();
        absorb(16'h1234, 1'b1, 0, "fin_basic");
        absorb(16'h5678, 1'b1, 0, "fin_basic");
        finalize(3, "fin_basic");
    endtask

    task automatic test_full_block();
        absorb(16'h0001, 1'b1, 0, "full_blk");
        absorb(16'h0002, 1'b1, 0, "full_blk");
        absorb(16'h0003, 1'b1, 0, "full_blk");
        absorb(16'h0004, 1'b1, 2, "full_blk");
        finalize(1, "full_pad");
    endtask

    task automatic test_short_word();
        absorb(16'hAAAA, 1'b1, 0, "short");
        absorb(16'h0001, 1'b0, 0, "short");
        finalize(0, "short");
    endtask

    task automatic test_digest_out();
        read_digest(128'h00112233445566778899AABBCCDDEEFF, 9, "digest");
    endtask

    task automatic test_reset_in_flush();
        logic b;
        logic [8*RB-1:0] exp;
        for (int i = 0; i < 4; i++) begin
            pend.push_back(8'(i * 17 + 3));
            pend.push_back(8'(i * 29 + 5));
            pulse(1'b1, 1'b1, {8'(i * 17 + 3), 8'(i * 29 + 5)}, b);
        end
        checks++;
        if (b !== 1'b1) begin
            errors++;
            $display("FAIL flush_rst 4th busy: got %b required 1", b);
        end
        exp = pop_block();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.blk_valid !== 1'b1 || bus.blk_data !== exp || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL flush_rst hold: got valid=%b data=%h busy=%b required 1 %h 1",
                         bus.blk_valid, bus.blk_data, bus.busy, exp);
            end
        end
        @(negedge clk) bus.hmac_reset = 1'b1;
        @(posedge clk); #1 bus.hmac_reset = 1'b0;
        pend.delete();
        checks++;
        if (bus.blk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.core_clear !== 1'b1 ||
            bus.blk_data !== '0) begin
            errors++;
            $display("FAIL flush_rst clear: got valid=%b busy=%b clr=%b data=%h required 0 0 1 0",
                     bus.blk_valid, bus.busy, bus.core_clear, bus.blk_data);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.core_clear !== 1'b0) begin
            errors++;
            $display("FAIL flush_rst core_clear pulse: got %b required 0", bus.core_clear);
        end
        absorb(16'h1234, 1'b1, 0, "flush_rst_fresh");
        absorb(16'h5678, 1'b1, 0, "flush_rst_fresh");
        finalize(0, "flush_rst_fresh");
    endtask

    task automatic test_split();
        absorb(16'h0011, 1'b0, 0, "split");
        absorb(16'h0022, 1'b0, 0, "split");
        absorb(16'h0033, 1'b0, 0, "split");
        absorb(16'h4455, 1'b1, 0, "split");
        absorb(16'h6677, 1'b1, 0, "split");
        absorb(16'h8899, 1'b1, 2, "split");
        finalize(0, "split_pad");
    endtask

    task automatic test_random();
        for (int m = 0; m < 15; m++) begin
            soft_reset();
            for (int w = 0; w < int'($urandom_range(0, 14)); w++) begin
                absorb(16'($urandom), 1'($urandom % 2), int'($urandom_range(0, 3)), "random");
            end
            finalize(int'($urandom_range(0, 3)), "random");
            read_digest({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(1, 10)), "random_dig");
        end
    endtask

    initial begin
        bus.hmac_reset     = 1'b0;
        bus.start_continue = 1'b0;
        bus.data_available = 1'b0;
        bus.data_is_long   = 1'b0;
        bus.data_in        = 16'h0;
        bus.blk_ready      = 1'b0;
        bus.digest_valid   = 1'b0;
        bus.digest         = '0;
        test_reset();
        test_finalize_basic();
        soft_reset();
        test_full_block();
        soft_reset();
        test_short_word();
        test_digest_out();
        soft_reset();
        test_reset_in_flush();
        soft_reset();
        test_split();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
